adc_scan_streamer: RTL and testbench

ADC_SCAN_STREAMER -- requirements
Module: adc_scan_streamer

---
 rtl/adc_scan_streamer.sv | 222 ++++++++++++++++++++++
 tb/tb_adc_scan_streamer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_streamer.sv
// Scans enabled ADC channels into a sample FIFO and streams every sample over a
// byte UART as A5 / {0,ch,msb} / lsb frames. Define CHECKSUM_EN to append an XOR byte.
module adc_scan_streamer #(
  parameter int NUM_CH    = 8,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_start,
  output logic [2:0]        adc_addr,
  input  logic              adc_done,
  input  logic [11:0]       adc_data,
  output logic              uart_en,
  output logic [7:0]        uart_data,
  input  logic              uart_done,
  output logic              busy,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
`ifdef CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT} scan_state_t;
  typedef enum logic [1:0] {P_IDLE, P_LOAD, P_SEND, P_WAIT} pack_state_t;

  scan_state_t       s_q, s_d;
  pack_state_t       p_q, p_d;
  logic              mode_q, mode_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [2:0]        ch_q, ch_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              stop_q, stop_d;
  logic              ovf_q, ovf_d;

  logic [14:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       lvl_q;
  logic              push, pop, wr_en, drop, full, empty;

  logic [14:0]       smp_q, smp_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        tx_q, tx_d;

  function automatic logic [2:0] first_en(input logic [NUM_CH-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CH-1; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Next enabled channel strictly after c, ascending with wrap; c itself if it is the only one.
  function automatic logic [2:0] next_en(input logic [NUM_CH-1:0] m, input logic [2:0] c);
    logic [2:0] r;
    logic       found;
    int         j;
    r = c;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      j = (int'(c) + i) % NUM_CH;
      if (!found && m[j]) begin
        r = 3'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [14:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'hA5;
      2'd1:    b = {1'b0, s[14:12], s[11:8]};
`ifdef CHECKSUM_EN
      2'd2:    b = s[7:0];
      default: b = 8'hA5 ^ {1'b0, s[14:12], s[11:8]} ^ s[7:0];
`else
      default: b = s[7:0];
`endif
    endcase
    return b;
  endfunction

  assign full  = (lvl_q == FULL_LVL);
  assign empty = (lvl_q == '0);
  assign push  = (s_q == S_WAIT) && adc_done;
  assign pop   = (p_q == P_LOAD) && !empty;
  // A push into a full FIFO still lands when the packer frees a slot the same cycle.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    s_d       = s_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    stop_d    = stop_q;
    ovf_d     = ovf_q | drop;
    adc_start = 1'b0;
    if (s_q != S_IDLE && stop) stop_d = 1'b1;
    case (s_q)
      S_IDLE: if (start && |ch_mask) begin
        mode_d = mode;
        mask_d = ch_mask;
        cnt_d  = '0;
        stop_d = 1'b0;
        ovf_d  = 1'b0;
        ch_d   = first_en(ch_mask);
        s_d    = S_REQ;
      end
      S_REQ: begin
        adc_start = 1'b1;
        s_d       = S_WAIT;
      end
      S_WAIT: if (adc_done) begin
        cnt_d = cnt_q + 16'd1;
        s_d   = S_NEXT;
      end
      S_NEXT: begin
        if ((!mode_q && cnt_q == 16'(BURST_LEN)) || (mode_q && (stop_q || stop))) begin
          s_d = S_IDLE;
        end else begin
          ch_d = next_en(mask_q, ch_q);
          s_d  = S_REQ;
        end
      end
      default: s_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_d     = p_q;
    smp_d   = smp_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    uart_en = 1'b0;
    case (p_q)
      P_IDLE: if (!empty) p_d = P_LOAD;
      P_LOAD: begin
        if (!empty) begin
          smp_d = mem_q[rd_q];
          idx_d = 2'd0;
          tx_d  = frame_byte(mem_q[rd_q], 2'd0);
          p_d   = P_SEND;
        end else begin
          p_d = P_IDLE;
        end
      end
      P_SEND: begin
        uart_en = 1'b1;
        p_d     = P_WAIT;
      end
      P_WAIT: if (uart_done) begin
        if (idx_q == LAST_BYTE) begin
          p_d = empty ? P_IDLE : P_LOAD;
        end else begin
          idx_d = idx_q + 2'd1;
          tx_d  = frame_byte(smp_q, idx_q + 2'd1);
          p_d   = P_SEND;
        end
      end
      default: p_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= S_IDLE;
      p_q    <= P_IDLE;
      mode_q <= 1'b0;
      mask_q <= '0;
      ch_q   <= '0;
      cnt_q  <= '0;
      stop_q <= 1'b0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      idx_q  <= '0;
      tx_q   <= '0;
    end else begin
      s_q    <= s_d;
      p_q    <= p_d;
      mode_q <= mode_d;
      mask_q <= mask_d;
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      stop_q <= stop_d;
      ovf_q  <= ovf_d;
      idx_q  <= idx_d;
      tx_q   <= tx_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {ch_q, adc_data};
    smp_q <= smp_d;
  end

  assign adc_addr  = ch_q;
  assign uart_data = tx_q;
  assign overflow  = ovf_q;
  assign busy      = (s_q != S_IDLE) || !empty || (p_q != P_IDLE);

endmodule

// File: tb/tb_adc_scan_streamer.sv
// Randomised bench for adc_scan_streamer: ADC and UART responders feed a
// frame-level reference model (expected byte queue) checked on every uart_en.
`timescale 1ns/1ps
module tb_adc_scan_streamer;
  localparam int NUM_CH    = 8;
  localparam int DEPTH     = 4;
  localparam int BURST_LEN = 4;
`ifdef CHECKSUM_EN
  localparam int FB = 4;
  logic [7:0] lit031 [16] = '{8'hA5, 8'h01, 8'h23, 8'h87, 8'hA5, 8'h21, 8'h23, 8'hA7,
                              8'hA5, 8'h01, 8'h23, 8'h87, 8'hA5, 8'h21, 8'h23, 8'hA7};
  logic [7:0] lit035 [4]  = '{8'hA5, 8'h3A, 8'hBC, 8'h23};
`else
  localparam int FB = 3;
  logic [7:0] lit031 [12] = '{8'hA5, 8'h01, 8'h23, 8'hA5, 8'h21, 8'h23,
                              8'hA5, 8'h01, 8'h23, 8'hA5, 8'h21, 8'h23};
  logic [7:0] lit035 [3]  = '{8'hA5, 8'h3A, 8'hBC};
`endif
  int lit_addr031 [4] = '{0, 2, 0, 2};

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic              adc_start, adc_done = 1'b0;
  logic [2:0]        adc_addr;
  logic [11:0]       adc_data = '0;
  logic              uart_en, uart_done = 1'b0;
  logic [7:0]        uart_data;
  logic              busy, overflow;

  adc_scan_streamer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .ch_mask(ch_mask),
    .adc_start(adc_start), .adc_addr(adc_addr), .adc_done(adc_done), .adc_data(adc_data),
    .uart_en(uart_en), .uart_data(uart_data), .uart_done(uart_done),
    .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_bytes[$];
  logic [7:0] obs_bytes[$];
  int         obs_addr[$];
  int         exp_ch = 0, model_mask = 0, n_conv = 0, held = 0, rst_gen = 0, last_done_cyc = 0;
  bit         stall = 0, lat_chk = 1, exp_overflow = 0, fixed_en = 0;
  logic [11:0] fixed_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int ch, input int data, input int idx);
    logic [7:0] b1, b2;
    b1 = 8'(((ch & 7) << 4) | ((data >> 8) & 15));
    b2 = 8'(data & 255);
    case (idx)
      0:       return 8'hA5;
      1:       return b1;
      2:       return b2;
      default: return 8'hA5 ^ b1 ^ b2;
    endcase
  endfunction

  function automatic int next_ch(input int mask, input int ch);
    for (int i = 1; i <= NUM_CH; i++)
      if (((mask >> ((ch + i) % NUM_CH)) & 1) != 0) return (ch + i) % NUM_CH;
    return ch;
  endfunction

  // ADC core: answers each adc_start after a random latency with random data.
  initial begin : adc_resp
    forever begin
      @(negedge clk);
      if (!rst && adc_start) begin
        int g, lat;
        logic [2:0] a;
        logic [11:0] d;
        g = rst_gen;
        a = adc_addr;
        n_conv++;
        obs_addr.push_back(int'(a));
        chk("adc_addr", a, exp_ch);
        exp_ch = next_ch(model_mask, exp_ch);
        lat = stall ? $urandom_range(3, 6) : $urandom_range(20, 30);
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst_gen != g) break;
          chk("adc_addr_hold", adc_addr, a);
          if (i == 0) chk("adc_start_single", adc_start, 0);
        end
        if (rst_gen == g) begin
          d = fixed_en ? fixed_data : 12'($urandom_range(0, 4095));
          adc_data = d;
          adc_done = 1'b1;
          last_done_cyc = cyc;
          if (!stall || held < DEPTH + 1) begin
            for (int k = 0; k < FB; k++) exp_bytes.push_back(frame_byte(int'(a), int'(d), k));
            if (stall) held++;
          end else begin
            exp_overflow = 1;
          end
          @(negedge clk);
          adc_done = 1'b0;
        end
      end
    end
  end

  // UART: checks every byte against the model and acknowledges unless stalled.
  initial begin : uart_resp
    int pos, g, lat;
    bit have;
    logic [7:0] b, e;
    pos = 0;
    have = 0;
    forever begin
      if (!have) @(negedge clk);
      have = 0;
      if (rst) pos = 0;
      else if (uart_en) begin
        g = rst_gen;
        b = uart_data;
        obs_bytes.push_back(b);
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL uart_unexpected: got uart_en with byte 0x%0h, required none", b);
        end else begin
          e = exp_bytes.pop_front();
          chk("uart_byte", b, e);
        end
        if (pos == 0 && lat_chk) chk("hdr_latency", cyc - last_done_cyc, 3);
        pos = (pos + 1) % FB;
        while (stall && rst_gen == g) @(negedge clk);
        if (rst_gen == g) begin
          lat = $urandom_range(1, 2);
          for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("uart_data_hold", uart_data, b);
            if (i == 0) chk("uart_en_single", uart_en, 0);
          end
          uart_done = 1'b1;
          @(negedge clk);
          uart_done = 1'b0;
          if (pos != 0) begin
            chk("uart_en_next", uart_en, 1);
            have = 1;
          end
        end else begin
          pos = 0;
        end
      end
    end
  end

  task automatic do_start(input bit m, input int mask);
    @(negedge clk);
    mode = m;
    ch_mask = NUM_CH'(mask);
    start = 1'b1;
    if (mask != 0) begin
      model_mask = mask;
      exp_ch = next_ch(mask, NUM_CH - 1);
      exp_overflow = 0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("adc_start_latency", adc_start, (mask != 0) ? 1 : 0);
    if (mask != 0) chk("overflow_clear_on_start", overflow, 0);
  endtask

  task automatic wait_conv(input int n);
    int t;
    t = 0;
    while (n_conv < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (n_conv < n) begin
      checks++;
      errors++;
      $display("FAIL wait_conv: conversions %0d, required %0d", n_conv, n);
    end
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_bytes.size() != 0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_busy", busy, 0);
    chk("idle_pending_bytes", exp_bytes.size(), 0);
  endtask

  initial begin : main
    int base, k, expn;
    bit m;
    int mask;
    repeat (3) @(negedge clk);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_uart_en", uart_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_adc_addr", adc_addr, 0);
    chk("rst_uart_data", uart_data, 0);
    rst = 1'b0;

    chk("pin_hdr", frame_byte(0, 'h123, 0), 'hA5);
    chk("pin_b1_ch0", frame_byte(0, 'h123, 1), 'h01);
    chk("pin_b1_ch2", frame_byte(2, 'h123, 1), 'h21);
    chk("pin_b1_ch3", frame_byte(3, 'hABC, 1), 'h3A);
    chk("pin_b2", frame_byte(3, 'hABC, 2), 'hBC);
    chk("pin_xor", frame_byte(3, 'hABC, 3), 'h23);
    chk("pin_next_wrap", next_ch(5, 2), 0);
    chk("pin_next_up", next_ch(5, 0), 2);

    // Zero mask start is ignored.
    base = n_conv;
    do_start(1'b0, 0);
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) k++;
    end
    chk("zero_mask_busy_cycles", k, 0);
    chk("zero_mask_conversions", n_conv - base, 0);

    // Single burst, mask 05, fixed data 0x123.
    fixed_en = 1;
    fixed_data = 12'h123;
    obs_bytes.delete();
    obs_addr.delete();
    do_start(1'b0, 'h05);
    wait_idle();
    chk("burst_addr_count", obs_addr.size(), 4);
    chk("burst_byte_count", obs_bytes.size(), 4 * FB);
    if (obs_addr.size() == 4) foreach (lit_addr031[i]) chk("burst_addr_seq", obs_addr[i], lit_addr031[i]);
    if (obs_bytes.size() == 4 * FB) foreach (lit031[i]) chk("burst_bytes", obs_bytes[i], lit031[i]);

    // Continuous on ch7, stop during the 3rd conversion.
    fixed_en = 0;
    obs_bytes.delete();
    obs_addr.delete();
    base = n_conv;
    do_start(1'b1, 'h80);
    wait_conv(base + 3);
    pulse_stop();
    wait_idle();
    chk("stop_conversions", n_conv - base, 3);
    chk("stop_frames", obs_bytes.size(), 3 * FB);
    foreach (obs_addr[i]) chk("stop_addr_ch7", obs_addr[i], 7);
    for (int i = 0; i < obs_bytes.size() / FB; i++) chk("stop_frame_ch7", obs_bytes[i*FB+1][6:4], 7);

    // Sample ch3 data 0xABC.
    fixed_en = 1;
    fixed_data = 12'hABC;
    obs_bytes.delete();
    do_start(1'b0, 'h08);
    wait_idle();
    if (obs_bytes.size() >= FB) foreach (lit035[i]) chk("ch3_abc_bytes", obs_bytes[i], lit035[i]);
    else chk("ch3_abc_count", obs_bytes.size(), FB);
    fixed_en = 0;

    // Randomised bursts against the model.
    for (int it = 0; it < 10; it++) begin
      m = 1'($urandom_range(0, 1));
      mask = $urandom_range(1, 255);
      base = n_conv;
      do_start(m, mask);
      if (m) begin
        expn = $urandom_range(1, 5);
        wait_conv(base + expn);
        pulse_stop();
      end else begin
        expn = BURST_LEN;
      end
      wait_idle();
      chk("rand_conversions", n_conv - base, expn);
      chk("rand_overflow", overflow, 0);
    end

    // UART stalled: 6 conversions, one frame in the packer plus DEPTH queued, the rest dropped.
    stall = 1;
    lat_chk = 0;
    held = 0;
    obs_bytes.delete();
    obs_addr.delete();
    base = n_conv;
    do_start(1'b1, 'h01);
    wait_conv(base + 6);
    pulse_stop();
    repeat (30) @(negedge clk);
    chk("ovf_conversions", n_conv - base, 6);
    chk("ovf_flag", overflow, exp_overflow);
    chk("ovf_flag_lit", overflow, 1);
    stall = 0;
    wait_idle();
    chk("ovf_frames", obs_bytes.size(), (DEPTH + 1) * FB);
    chk("ovf_sticky", overflow, 1);

    // Reset in the middle of a frame.
    stall = 1;
    held = 0;
    obs_bytes.delete();
    do_start(1'b1, 'h01);
    k = 0;
    while (obs_bytes.size() == 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rst_test_header_seen", obs_bytes.size(), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    rst_gen++;
    exp_bytes.delete();
    held = 0;
    #1;
    chk("midrst_uart_en", uart_en, 0);
    chk("midrst_uart_data", uart_data, 0);
    chk("midrst_adc_start", adc_start, 0);
    chk("midrst_adc_addr", adc_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overflow", overflow, 0);
    stall = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n_conv;
    k = obs_bytes.size();
    repeat (40) @(negedge clk);
    chk("postrst_no_uart", obs_bytes.size(), k);
    chk("postrst_no_adc", n_conv - base, 0);
    chk("postrst_busy", busy, 0);
    lat_chk = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
